// File: rtl/sid_sched_pkg.sv
// Shared types and constants for the SID lookup/filter sequencer.
//   sched_state_e : sequencer FSM states
//   FILT_PHASES   : filter engine phases per chip
//   LUT_W / RES_W : table address and table result widths
package sid_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_FILTER = 3'd3,
    S_DONE   = 3'd4
  } sched_state_e;

  localparam int FILT_PHASES = 8;
  localparam int LUT_W       = 12;
  localparam int RES_W       = 32;

endpackage

// File: rtl/sid_lut_capture.sv
// Capture side of the shared waveform-table port. A LUT_LAT-deep delay line
// carries {valid, voice} alongside the table pipeline; when the tail entry is
// valid the table result is written into that voice's register.
//   clk, rst_n : clock, async active-low reset
//   flush      : drop everything in flight (sequence abort)
//   req_i      : lookup issued this clock
//   voice_i    : voice index of the lookup issued this clock
//   lut_data   : table result, aligned with the delay-line tail
//   wav_out    : per-voice captured results
module sid_lut_capture
  import sid_sched_pkg::*;
#(
  parameter int VOICES  = 6,
  parameter int VW      = 3,
  parameter int LUT_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          req_i,
  input  logic [VW-1:0]                 voice_i,
  input  logic [RES_W-1:0]              lut_data,
  output logic [VOICES-1:0][RES_W-1:0]  wav_out
);

  // stage i holds a lookup issued i+1 clocks ago; stage LUT_LAT-1 is the tail
  logic [LUT_LAT-1:0]         vld_pipe_q, vld_pipe_d;
  logic [LUT_LAT-1:0][VW-1:0] vid_pipe_q, vid_pipe_d;
  logic [VOICES-1:0][RES_W-1:0] wav_q, wav_d;
  logic tail_vld;

  // an abort also suppresses the write landing on the same edge
  assign tail_vld = vld_pipe_q[LUT_LAT-1] && !flush;

  always_comb begin
    vld_pipe_d    = '0;
    vid_pipe_d    = vid_pipe_q;
    vid_pipe_d[0] = voice_i;
    if (!flush) begin
      vld_pipe_d[0] = req_i;
      for (int i = 1; i < LUT_LAT; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        vid_pipe_d[i] = vid_pipe_q[i-1];
      end
    end
    wav_d = wav_q;
    for (int v = 0; v < VOICES; v++) begin
      if (tail_vld && vid_pipe_q[LUT_LAT-1] == VW'(v)) wav_d[v] = lut_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      vid_pipe_q <= '0;
      wav_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      vid_pipe_q <= vid_pipe_d;
      wav_q      <= wav_d;
    end
  end

  assign wav_out = wav_q;

endmodule

// File: rtl/sid_lut_sched.sv
// Per-SID-cycle sequencer for the shared waveform-table port and filter
// engine. On ce_1m it snapshots all voice accumulator taps, issues one table
// lookup per voice on back-to-back clocks, waits for the table pipeline to
// drain, then walks the filter through 8 phases per chip, strobing each
// chip's audio capture on its last phase.
//   clk, reset_n        : clock, async active-low reset
//   ce_1m               : 1 MHz SID cycle enable
//   acc_t_in            : accumulator taps, voice v at [12v+:12]
//   lut_req/addr/voice  : table lookup issue
//   lut_data            : table result, LUT_LAT clocks after lut_req
//   wav_out             : captured per-voice table results
//   filt_chip/state/run : filter ownership and phase
//   audio_stb           : per-chip audio capture strobe
//   busy, done          : sequence in progress / completion pulse
//   overrun,clr_overrun : sticky ce_1m-while-busy flag and its clear
module sid_lut_sched
  import sid_sched_pkg::*;
#(
  parameter int CHIPS   = 2,
  parameter int VOICES  = 3*CHIPS,
  parameter int LUT_LAT = 2,
  parameter int VW      = $clog2(VOICES)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce_1m,
  input  logic [LUT_W*VOICES-1:0]  acc_t_in,
  output logic                     lut_req,
  output logic [LUT_W-1:0]         lut_addr,
  output logic [VW-1:0]            lut_voice,
  input  logic [RES_W-1:0]         lut_data,
  output logic [RES_W*VOICES-1:0]  wav_out,
  output logic                     filt_chip,
  output logic [2:0]               filt_state,
  output logic                     filt_run,
  output logic [CHIPS-1:0]         audio_stb,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int DW = $clog2(LUT_LAT+1);
  localparam logic [VW-1:0] LAST_V  = VW'(VOICES-1);
  localparam logic          LAST_C  = 1'(CHIPS-1);
  localparam logic [2:0]    LAST_PH = 3'(FILT_PHASES-1);

  sched_state_e state_q, state_d;
  logic [VOICES-1:0][LUT_W-1:0] snap_q, snap_d;
  logic [VW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             chip_q, chip_d;
  logic [2:0]       phase_q, phase_d;
  logic             lut_req_q, lut_req_d;
  logic [LUT_W-1:0] lut_addr_q, lut_addr_d;
  logic [VW-1:0]    lut_voice_q, lut_voice_d;
  logic             filt_run_q, filt_run_d;
  logic [CHIPS-1:0] audio_stb_q, audio_stb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             abort;
  logic [VOICES-1:0][RES_W-1:0] wav_q;

  // ce_1m in any non-idle state (DONE included) restarts the sequence
  assign abort = ce_1m && (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    chip_d    = chip_q;
    phase_d   = phase_q;
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (ce_1m) begin
      if (abort) overrun_d = 1'b1;
      state_d = S_ISSUE;
      snap_d  = acc_t_in;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ISSUE: begin
          if (cnt_q == LAST_V) begin
            state_d = S_DRAIN;
            dcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // LUT_LAT drain clocks cover the last lookup's round trip
        S_DRAIN: begin
          if (dcnt_q == DW'(LUT_LAT-1)) begin
            state_d = S_FILTER;
            chip_d  = 1'b0;
            phase_d = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        S_FILTER: begin
          if (phase_q == LAST_PH) begin
            if (chip_q == LAST_C) begin
              state_d = S_DONE;
            end else begin
              chip_d  = chip_q + 1'b1;
              phase_d = '0;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // outputs are registered, decoded from the state being entered
    lut_req_d   = (state_d == S_ISSUE);
    lut_addr_d  = lut_req_d ? snap_d[cnt_d] : '0;
    lut_voice_d = lut_req_d ? cnt_d : '0;
    filt_run_d  = (state_d == S_FILTER);
    audio_stb_d = '0;
    for (int c = 0; c < CHIPS; c++) begin
      audio_stb_d[c] = filt_run_d && (phase_d == LAST_PH) && (chip_d == 1'(c));
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      chip_q      <= 1'b0;
      phase_q     <= '0;
      lut_req_q   <= 1'b0;
      lut_addr_q  <= '0;
      lut_voice_q <= '0;
      filt_run_q  <= 1'b0;
      audio_stb_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      chip_q      <= chip_d;
      phase_q     <= phase_d;
      lut_req_q   <= lut_req_d;
      lut_addr_q  <= lut_addr_d;
      lut_voice_q <= lut_voice_d;
      filt_run_q  <= filt_run_d;
      audio_stb_q <= audio_stb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  sid_lut_capture #(
    .VOICES  (VOICES),
    .VW      (VW),
    .LUT_LAT (LUT_LAT)
  ) u_cap (
    .clk      (clk),
    .rst_n    (reset_n),
    .flush    (abort),
    .req_i    (lut_req_q),
    .voice_i  (lut_voice_q),
    .lut_data (lut_data),
    .wav_out  (wav_q)
  );

  assign lut_req    = lut_req_q;
  assign lut_addr   = lut_addr_q;
  assign lut_voice  = lut_voice_q;
  assign wav_out    = wav_q;
  assign filt_chip  = chip_q;
  assign filt_state = phase_q;
  assign filt_run   = filt_run_q;
  assign audio_stb  = audio_stb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sid_lut_sched.sv
module tb_sid_lut_sched;
  localparam int CHIPS = 2, VOICES = 6, LAT = 2, VW = 3;
  localparam int TOTAL = 1 + VOICES + LAT + 8*CHIPS;

  logic clk, reset_n, ce_1m, clr_overrun;
  logic [12*VOICES-1:0] acc_t_in;
  logic lut_req, filt_chip, filt_run, busy, done, overrun;
  logic [11:0] lut_addr;
  logic [VW-1:0] lut_voice;
  logic [31:0] lut_data;
  logic [32*VOICES-1:0] wav_out;
  logic [2:0] filt_state;
  logic [CHIPS-1:0] audio_stb;

  // second instance: one chip, 4-clock table
  logic ce1;
  logic [35:0] acc1;
  logic lut_req1, filt_chip1, filt_run1, busy1, done1, overrun1;
  logic [11:0] lut_addr1;
  logic [1:0] lut_voice1;
  logic [31:0] lut_data1;
  logic [95:0] wav1;
  logic [2:0] filt_state1;
  logic [0:0] audio_stb1;

  sid_lut_sched #(.CHIPS(CHIPS), .LUT_LAT(LAT)) u0 (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .acc_t_in(acc_t_in),
    .lut_req(lut_req), .lut_addr(lut_addr), .lut_voice(lut_voice), .lut_data(lut_data),
    .wav_out(wav_out), .filt_chip(filt_chip), .filt_state(filt_state), .filt_run(filt_run),
    .audio_stb(audio_stb), .busy(busy), .done(done), .overrun(overrun), .clr_overrun(clr_overrun));

  sid_lut_sched #(.CHIPS(1), .LUT_LAT(4)) u1 (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce1), .acc_t_in(acc1),
    .lut_req(lut_req1), .lut_addr(lut_addr1), .lut_voice(lut_voice1), .lut_data(lut_data1),
    .wav_out(wav1), .filt_chip(filt_chip1), .filt_state(filt_state1), .filt_run(filt_run1),
    .audio_stb(audio_stb1), .busy(busy1), .done(done1), .overrun(overrun1), .clr_overrun(1'b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // table models: result = {4{addr[7:0]}}, LAT clocks after the address
  logic [11:0] ap0 [LAT];
  logic [11:0] ap1 [4];
  always @(posedge clk) begin
    ap0[0] <= lut_addr;
    for (int i = 1; i < LAT; i++) ap0[i] <= ap0[i-1];
    ap1[0] <= lut_addr1;
    for (int i = 1; i < 4; i++) ap1[i] <= ap1[i-1];
  end
  assign lut_data  = {4{ap0[LAT-1][7:0]}};
  assign lut_data1 = {4{ap1[3][7:0]}};

  typedef struct { int cyc; logic [11:0] addr; int voice; } lut_exp_t;
  typedef struct { int cyc; int chip; int ph; logic [CHIPS-1:0] stb; } filt_exp_t;
  typedef struct { int cyc; logic [32*VOICES-1:0] wav; } done_exp_t;

  lut_exp_t  q_lut[$];
  filt_exp_t q_filt[$];
  done_exp_t q_done[$];
  int n_tests = 0, n_fail = 0;
  bit active = 0, exp_ovr = 0, rand_acc = 0;
  int start = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor: compares whatever the DUT presents against the queues
  always @(negedge clk) begin
    lut_exp_t le;
    filt_exp_t fe;
    done_exp_t de;
    while (q_lut.size() > 0 && q_lut[0].cyc < cyc) begin
      chk("lut_missing", 0, 1); void'(q_lut.pop_front());
    end
    while (q_filt.size() > 0 && q_filt[0].cyc < cyc) begin
      chk("filt_missing", 0, 1); void'(q_filt.pop_front());
    end
    while (q_done.size() > 0 && q_done[0].cyc < cyc) begin
      chk("done_missing", 0, 1); void'(q_done.pop_front());
    end
    if (lut_req) begin
      if (q_lut.size() == 0) chk("lut_unexpected", 1, 0);
      else begin
        le = q_lut.pop_front();
        chk("lut_cycle", cyc, le.cyc);
        chk("lut_addr", lut_addr, le.addr);
        chk("lut_voice", lut_voice, le.voice);
      end
    end
    if (filt_run) begin
      if (q_filt.size() == 0) chk("filt_unexpected", 1, 0);
      else begin
        fe = q_filt.pop_front();
        chk("filt_cycle", cyc, fe.cyc);
        chk("filt_chip", filt_chip, fe.chip);
        chk("filt_state", filt_state, fe.ph);
        chk("audio_stb", audio_stb, fe.stb);
      end
    end else chk("audio_stb_idle", audio_stb, 0);
    if (done) begin
      if (q_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        de = q_done.pop_front();
        chk("done_cycle", cyc, de.cyc);
        chk("wav_out", wav_out, de.wav);
      end
    end
    chk("busy", busy, active && cyc > start && cyc <= start + TOTAL);
    chk("overrun", overrun, exp_ovr);
  end

  task automatic step();
    @(negedge clk); #1;
    if (rand_acc) for (int v = 0; v < VOICES; v++) acc_t_in[v*12 +: 12] = 12'($urandom);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  // issue ce_1m and push the whole expected sequence
  task automatic fire(input bit clr);
    logic [VOICES-1:0][11:0] snap;
    logic [32*VOICES-1:0] wav;
    bit hit;
    snap = acc_t_in;
    hit = active && (cyc <= start + TOTAL);
    if (hit) begin q_lut.delete(); q_filt.delete(); q_done.delete(); end
    exp_ovr = hit ? 1'b1 : (clr ? 1'b0 : exp_ovr);
    start = cyc;
    active = 1;
    for (int v = 0; v < VOICES; v++) begin
      q_lut.push_back('{cyc + 1 + v, snap[v], v});
      wav[v*32 +: 32] = {4{snap[v][7:0]}};
    end
    for (int ch = 0; ch < CHIPS; ch++)
      for (int ph = 0; ph < 8; ph++)
        q_filt.push_back('{cyc + 1 + VOICES + LAT + 8*ch + ph, ch, ph,
                           (ph == 7) ? CHIPS'(1 << ch) : CHIPS'(0)});
    q_done.push_back('{cyc + TOTAL, wav});
    ce_1m = 1'b1; clr_overrun = clr;
    step();
    ce_1m = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic clr_only();
    clr_overrun = 1'b1; exp_ovr = 1'b0;
    step();
    clr_overrun = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_outputs"}, {lut_req, lut_addr, lut_voice, filt_chip, filt_state, filt_run,
                            audio_stb, busy, done, overrun}, 0);
    chk({tag, "_wav"}, wav_out, 0);
  endtask

  task automatic run_u1();
    logic [2:0][11:0] s;
    int c, nreq, nstb, done_at;
    for (int v = 0; v < 3; v++) acc1[v*12 +: 12] = 12'($urandom);
    s = acc1;
    c = cyc; nreq = 0; nstb = 0; done_at = -1;
    ce1 = 1'b1; step(); ce1 = 1'b0;
    repeat (30) begin
      if (lut_req1) nreq++;
      if (audio_stb1[0]) nstb++;
      if (done1 && done_at < 0) done_at = cyc;
      step();
    end
    chk("u1_done_latency", done_at - c, 16);
    chk("u1_lut_reqs", nreq, 3);
    chk("u1_audio_stb", nstb, 1);
    chk("u1_overrun", overrun1, 0);
    for (int v = 0; v < 3; v++) chk("u1_wav", wav1[v*32 +: 32], {4{s[v][7:0]}});
  endtask

  initial begin
    reset_n = 1'b1; ce_1m = 1'b0; clr_overrun = 1'b0; acc_t_in = '0;
    ce1 = 1'b0; acc1 = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    reset_n = 1'b1;
    step();

    // directed: taps 100+v, then taps change while lookups are issuing
    for (int v = 0; v < VOICES; v++) acc_t_in[v*12 +: 12] = 12'h100 + 12'(v);
    fire(0);
    rand_acc = 1;
    wait_cyc(30);

    // early ce_1m 10 clocks after, then a third early one with clr
    fire(0); wait_cyc(9); fire(0); wait_cyc(4); fire(1);
    wait_cyc(30); clr_only(); wait_cyc(2);

    // ce_1m in the DONE clock (gap 25) versus the first idle clock (gap 26)
    fire(0); wait_cyc(24); fire(0); wait_cyc(25); fire(0);
    wait_cyc(30); clr_only(); wait_cyc(2);

    // random spacing, some overlapping, random clears
    repeat (20) begin
      fire($urandom_range(0, 3) == 0);
      wait_cyc($urandom_range(8, 35));
    end
    wait_cyc(30);

    // async reset in the middle of the filter walk
    fire(0); wait_cyc(14);
    reset_n = 1'b0;
    q_lut.delete(); q_filt.delete(); q_done.delete();
    active = 0; exp_ovr = 0;
    #1 check_zero("async_reset");
    step();
    reset_n = 1'b1;
    wait_cyc(40);

    run_u1();
    wait_cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sid_lut_sched.md
Name: sid_lut_sched

Overview:
Sequencer that time-shares one waveform-table lookup port and one state-variable filter engine among all SID voices and chips within each 1 MHz SID cycle. On each ce_1m it snapshots every voice's 12-bit accumulator tap and issues one table lookup per voice on consecutive clocks. It captures the pipelined table results into per-voice registers, then steps the filter engine through 8 phases per chip and strobes each chip's audio capture. It sits between the sid_voice instances and the shared sid_tables/sid_filter pair, replacing ad-hoc state counters.

Parameters:
CHIPS, 2, number of SID chips sharing the resources (1 or 2)
VOICES, 3*CHIPS, total voices; voice v belongs to chip v/3
LUT_LAT, 2, clocks from lut_addr valid to lut_data valid (1..4)
VW, $clog2(VOICES), width of voice index

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce_1m  in  1  1 MHz SID cycle enable, one clk wide
acc_t_in  in  12*VOICES  accumulator taps, voice v at [12v+:12]
lut_req  out  1  lookup issue strobe
lut_addr  out  12  lookup address (snapshotted acc_t)
lut_voice  out  VW  voice index of current issue (drives chip select of table mode/cfg)
lut_data  in  32  table result {pst,ps_,p_t,_st}, valid LUT_LAT clocks after lut_req
wav_out  out  32*VOICES  captured per-voice table results
filt_chip  out  1  chip currently owning the filter (0 when CHIPS=1)
filt_state  out  3  filter phase 0..7
filt_run  out  1  filter phase active
audio_stb  out  CHIPS  one-clk strobe: capture filter output for chip c
busy  out  1  sequence in progress
done  out  1  one-clk pulse at sequence completion
overrun  out  1  sticky: ce_1m arrived while busy
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (async, reset_n=0): all outputs 0, wav_out 0, snapshot 0, FSM IDLE, capture pipe invalid.
- FSM states: IDLE, ISSUE, DRAIN, FILTER, DONE.
- IDLE: ce_1m -> latch all acc_t_in into snapshot, voice counter=0, go ISSUE, busy=1 from next clk.
- ISSUE: each clk lut_req=1, lut_addr=snapshot[cnt], lut_voice=cnt; cnt increments; after voice VOICES-1 go DRAIN. Exactly VOICES issue clocks, no gaps.
- Capture pipe: LUT_LAT-deep shift of {valid,voice}; when the tail is valid, wav_out[voice] <= lut_data. Other voices hold.
- DRAIN: lut_req=0; wait until pipe empty (LUT_LAT clocks after last issue), then FILTER with chip=0, phase=0.
- FILTER: filt_run=1, filt_state=phase increments 0..7. audio_stb[chip] pulses in the clock where phase==7. After phase 7: if chip<CHIPS-1, chip++ and phase=0; else DONE.
- DONE: done=1 one clock, busy=0 next clock, return IDLE. filt_chip/filt_state hold last values; filt_run=0.
- Total latency ce_1m -> done: 1+VOICES+LUT_LAT+8*CHIPS clocks (defaults: 25). Must be less than clocks per ce_1m period; not checked in RTL.
- ce_1m while busy (any state except IDLE): overrun<=1; sequence aborts, pipe flushed (captures already made stay), new snapshot taken, restart at ISSUE voice 0. No audio_stb or done is issued for the aborted sequence.
- ce_1m in the DONE clock counts as busy: overrun, restart.
- clr_overrun clears overrun; same-clock set and clear -> set wins.
- Reset mid-sequence: immediate return to reset values; no done.

Decomposition:
- Package sid_sched_pkg: FSM state enum, FILT_PHASES=8, LUT_W=12, RES_W=32 constants.
- One sub-module, sid_lut_capture: the LUT_LAT-deep valid/voice-tag delay line plus write-enable decode into wav_out. The FSM stays in sid_lut_sched.

Test Plan:
- Defaults, acc_t_in voice v = 12'h100+v, table model returns {4{addr[7:0]}} with LAT=2, one ce_1m -> lut_addr 100..105 on 6 consecutive clocks; wav_out[v]=32'h0v0v0v0v; done 25 clocks after ce_1m.
- Same run, filter side: filt_chip=0 with filt_state 0..7, then chip 1 with 0..7; audio_stb=2'b01 at chip0 phase7, 2'b10 at chip1 phase7; overrun=0.
- CHIPS=1, LUT_LAT=4 -> 3 issues, drain 4 clocks, 8 filter phases; done 16 clocks after ce_1m; audio_stb[0] pulses once.
- Second ce_1m 10 clocks after the first -> overrun=1, new snapshot used, no done for the first sequence, done 25 clocks after the second ce_1m; clr_overrun together with a third early ce_1m -> overrun stays 1.
- Assert reset_n low during FILTER -> all outputs 0 asynchronously; after release, no done until the next ce_1m.
- Change acc_t_in during ISSUE -> lut_addr still shows the values snapshotted at ce_1m.
